id_fetch_frontend: RTL and testbench

//  Decode-side consumer of the fetch stage. Aligns the 1-cycle-latency I-memory word with its PC.

---
 rtl/id_fetch_frontend_pkg.sv | 16 +
 rtl/id_fetch_frontend_bp.sv | 25 ++
 rtl/id_fetch_frontend.sv | 72 +++++++
 tb/tb_id_fetch_frontend.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/id_fetch_frontend_pkg.sv
// id_fetch_frontend_pkg: opcode constants and immediate extraction shared by the ID front end
package id_fetch_frontend_pkg;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   function automatic logic [31:0] imm_j(input logic [31:0] instr);
      return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] instr);
      return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/id_fetch_frontend_bp.sv
// static_bp_decode: static BTFN/JAL predictor on the ID word, purely combinational
module static_bp_decode
   import id_fetch_frontend_pkg::*;
#(
   parameter logic PREDICT_BRANCH = 1'b1,
   parameter logic PREDICT_JAL    = 1'b1
) (
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   output logic        predict,
   output logic [31:0] target
);

   logic is_jal;
   logic is_br;

   always_comb begin
      is_jal  = instr[6:0] == OPC_JAL;
      is_br   = instr[6:0] == OPC_BRANCH;
      // JALR and everything else fall through as not taken
      predict = is_jal ? PREDICT_JAL : (is_br & PREDICT_BRANCH & instr[31]);
      target  = pc + (is_jal ? imm_j(instr) : imm_b(instr));
   end

endmodule

// File: rtl/id_fetch_frontend.sv
// id_fetch_frontend: aligns/holds the fetched word for decode, squashes wrong path, merges redirects
module id_fetch_frontend
   import id_fetch_frontend_pkg::*;
#(
   parameter logic PREDICT_BRANCH = 1'b1,
   parameter logic PREDICT_JAL    = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] instr_f_i,
   input  logic [31:0] pc_f_i,
   input  logic [31:0] pc_plus4_f_i,
   input  logic        stall_i,
   input  logic        ex_redirect_i,
   input  logic [31:0] ex_target_i,
   output logic        if_enable_o,
   output logic        if_taken_o,
   output logic [31:0] if_redirect_o,
   output logic [31:0] instr_d_o,
   output logic [31:0] pc_d_o,
   output logic [31:0] pc_plus4_d_o,
   output logic        valid_d_o,
   output logic        pred_taken_d_o
);

   logic        first_q;
   logic        kill_q;
   logic        hold_v_q;
   logic [31:0] hold_q;
   logic        predict;
   logic [31:0] pred_target;

   static_bp_decode #(
      .PREDICT_BRANCH (PREDICT_BRANCH),
      .PREDICT_JAL    (PREDICT_JAL)
   ) u_bp (
      .instr   (instr_d_o),
      .pc      (pc_f_i),
      .predict (predict),
      .target  (pred_target)
   );

   // outputs are forced to their quiet values while reset is asserted
   always_comb begin
      if_enable_o    = ~resetn | ~stall_i | ex_redirect_i;
      instr_d_o      = hold_v_q ? hold_q : instr_f_i;
      pc_d_o         = pc_f_i;
      pc_plus4_d_o   = pc_plus4_f_i;
      valid_d_o      = resetn & ~first_q & ~kill_q & ~ex_redirect_i;
      pred_taken_d_o = valid_d_o & predict;
      if_taken_o     = resetn & (ex_redirect_i | (pred_taken_d_o & ~stall_i));
      if_redirect_o  = ex_redirect_i ? ex_target_i : pred_target;
   end

   // fetch re-reads the next address while stalled, so the word is captured on stall entry
   always_ff @(posedge clk) begin
      if (!resetn) begin
         first_q  <= 1'b1;
         kill_q   <= 1'b0;
         hold_v_q <= 1'b0;
         hold_q   <= 32'h0;
      end else if (if_enable_o) begin
         first_q  <= 1'b0;
         kill_q   <= if_taken_o;
         hold_v_q <= 1'b0;
      end else if (!hold_v_q) begin
         hold_q   <= instr_f_i;
         hold_v_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_id_fetch_frontend.sv
// tb_id_fetch_frontend: scoreboard bench for two predictor configurations against a spec-level model
module tb_id_fetch_frontend;

   typedef struct {
      logic        ie, tk, v, pt;
      logic [31:0] rd, ins, pc, pc4;
      bit          chk_rd, chk_ins;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] instr_f = 32'h0, pc_f = 32'h0, pc4_f = 32'h4, ex_tgt = 32'h0;
   logic        stall = 1'b0, ex_red = 1'b0;

   logic        ie0, tk0, v0, pt0, ie1, tk1, v1, pt1;
   logic [31:0] rd0, ins0, pcd0, pc4d0, rd1, ins1, pcd1, pc4d1;

   int checks = 0;
   int failures = 0;

   exp_t q0[$];
   exp_t q1[$];

   bit          m_first[2], m_kill[2], m_held[2];
   logic [31:0] m_word[2];
   bit          cfg_pred[2] = '{1'b1, 1'b0};

   always #5 clk = ~clk;

   id_fetch_frontend u0 (
      .clk(clk), .resetn(resetn), .instr_f_i(instr_f), .pc_f_i(pc_f), .pc_plus4_f_i(pc4_f),
      .stall_i(stall), .ex_redirect_i(ex_red), .ex_target_i(ex_tgt),
      .if_enable_o(ie0), .if_taken_o(tk0), .if_redirect_o(rd0), .instr_d_o(ins0),
      .pc_d_o(pcd0), .pc_plus4_d_o(pc4d0), .valid_d_o(v0), .pred_taken_d_o(pt0)
   );

   id_fetch_frontend #(.PREDICT_BRANCH(1'b0), .PREDICT_JAL(1'b0)) u1 (
      .clk(clk), .resetn(resetn), .instr_f_i(instr_f), .pc_f_i(pc_f), .pc_plus4_f_i(pc4_f),
      .stall_i(stall), .ex_redirect_i(ex_red), .ex_target_i(ex_tgt),
      .if_enable_o(ie1), .if_taken_o(tk1), .if_redirect_o(rd1), .instr_d_o(ins1),
      .pc_d_o(pcd1), .pc_plus4_d_o(pc4d1), .valid_d_o(v1), .pred_taken_d_o(pt1)
   );

   // ISA-level view: decode opcode, rebuild the immediate arithmetically, decide taken
   function automatic void ref_predict(input logic [31:0] w, input logic [31:0] pc, input bit en,
                                       output bit p, output logic [31:0] t);
      int imm;
      p = 1'b0;
      imm = 0;
      if (w[6:0] == 7'h6F) begin
         imm = (w[31] ? -1048576 : 0) + (int'(w[19:12]) * 4096) + (int'(w[20]) * 2048)
             + (int'(w[30:21]) * 2);
         p = en;
      end else if (w[6:0] == 7'h63) begin
         imm = (w[31] ? -4096 : 0) + (int'(w[7]) * 2048) + (int'(w[30:25]) * 32)
             + (int'(w[11:8]) * 2);
         p = en && w[31];
      end
      t = pc + 32'(imm);
   endfunction

   task automatic step(input logic rn, input logic [31:0] pc, input logic [31:0] ins,
                       input logic st, input logic exr, input logic [31:0] tgt);
      exp_t e;
      bit p;
      logic [31:0] t;
      @(posedge clk);
      #1;
      resetn = rn; pc_f = pc; pc4_f = pc + 32'd4; instr_f = ins;
      stall = st; ex_red = exr; ex_tgt = tgt;
      for (int k = 0; k < 2; k++) begin
         e.pc = pc; e.pc4 = pc + 32'd4;
         if (!rn) begin
            e.ie = 1'b1; e.tk = 1'b0; e.v = 1'b0; e.pt = 1'b0;
            e.rd = 32'h0; e.ins = 32'h0; e.chk_rd = 1'b0; e.chk_ins = 1'b0;
            m_first[k] = 1'b1; m_kill[k] = 1'b0; m_held[k] = 1'b0; m_word[k] = 32'h0;
         end else begin
            e.ins = m_held[k] ? m_word[k] : ins;
            e.chk_ins = 1'b1;
            e.ie = !st || exr;
            e.v = !m_first[k] && !m_kill[k] && !exr;
            ref_predict(e.ins, pc, cfg_pred[k], p, t);
            e.pt = e.v && p;
            e.tk = exr || (e.pt && !st);
            e.rd = exr ? tgt : t;
            e.chk_rd = e.tk;
            if (e.ie) begin
               m_first[k] = 1'b0; m_kill[k] = e.tk; m_held[k] = 1'b0;
            end else if (!m_held[k]) begin
               m_held[k] = 1'b1; m_word[k] = ins;
            end
         end
         if (k == 0) q0.push_back(e);
         else q1.push_back(e);
      end
   endtask

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s[u%0d] @%0t got=%h want=%h", name, k, $time, act, exp_v);
      end
   endtask

   task automatic compare(input int k, input exp_t e, input logic ie, input logic tk, input logic v,
                          input logic pt, input logic [31:0] rd, input logic [31:0] ins,
                          input logic [31:0] pc, input logic [31:0] pc4);
      chk("if_enable", k, {31'h0, ie}, {31'h0, e.ie});
      chk("if_taken", k, {31'h0, tk}, {31'h0, e.tk});
      chk("valid_d", k, {31'h0, v}, {31'h0, e.v});
      chk("pred_taken", k, {31'h0, pt}, {31'h0, e.pt});
      chk("pc_d", k, pc, e.pc);
      chk("pc_plus4_d", k, pc4, e.pc4);
      if (e.chk_rd) chk("if_redirect", k, rd, e.rd);
      if (e.chk_ins) chk("instr_d", k, ins, e.ins);
   endtask

   always @(negedge clk) begin
      if (q0.size() > 0) compare(0, q0.pop_front(), ie0, tk0, v0, pt0, rd0, ins0, pcd0, pc4d0);
      if (q1.size() > 0) compare(1, q1.pop_front(), ie1, tk1, v1, pt1, rd1, ins1, pcd1, pc4d1);
   end

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom();
      case ($urandom_range(0, 4))
         0: return {r[31:7], 7'h6F};
         1, 2: return {r[31:7], 7'h63};
         3: return {r[31:7], 7'h67};
         default: return r;
      endcase
   endfunction

   localparam logic [31:0] ADDI = 32'h00100093;
   localparam logic [31:0] BEQ_M8 = 32'hFE000CE3;
   localparam logic [31:0] BNE_P16 = 32'h00001863;
   localparam logic [31:0] JAL_P100 = 32'h1000006F;

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_first[k] = 1'b1; m_kill[k] = 1'b0; m_held[k] = 1'b0; m_word[k] = 32'h0;
      end
      repeat (3) step(1'b0, 32'h0, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h0, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h0, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h4, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h8, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h20, BEQ_M8, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h24, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h18, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h1C, BNE_P16, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h20, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h40, JAL_P100, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h44, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h140, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h10, 32'h00A00093, 1'b1, 1'b0, 32'h0);
      step(1'b1, 32'h10, 32'h11111111, 1'b1, 1'b0, 32'h0);
      step(1'b1, 32'h10, 32'h22222222, 1'b1, 1'b0, 32'h0);
      step(1'b1, 32'h10, 32'h33333333, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h14, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h20, BEQ_M8, 1'b1, 1'b1, 32'h200);
      step(1'b1, 32'h24, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h200, ADDI, 1'b0, 1'b0, 32'h0);
      step(1'b1, 32'h10, ADDI, 1'b1, 1'b0, 32'h0);
      step(1'b0, 32'h10, ADDI, 1'b1, 1'b0, 32'h0);
      step(1'b1, 32'h0, ADDI, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 99) >= 2, $urandom() & 32'hFFFF_FFFC, rand_instr(),
              $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 12, $urandom() & 32'hFFFF_FFFC);
      for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
      checks++;
      if (q0.size() > 0 || q1.size() > 0) begin
         failures++;
         $display("FAIL drain got=%0d want=0", q0.size() + q1.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
